// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_pkg
//  Description : Shared types, widths and parameter defaults for the
//                reaction-time trial controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

   // Delay counter is wide enough for 1000 + 4095 ms.
   localparam int DELAY_W = 14;
   // Reaction time width; TIMEOUT_MS must fit in it (max 8191).
   localparam int TIME_W  = 13;

   localparam int DEF_MIN_DELAY_MS = 1000;
   localparam int DEF_TIMEOUT_MS   = 2000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      GO    = 3'd2,
      DONE  = 3'd3,
      CHEAT = 3'd4,
      TOUT  = 3'd5
   } state_t;

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/trial_timer.sv
`default_nettype none
// ============================================================================
//  Module      : trial_timer
//  Description : Loadable millisecond counter. Counts down while the trial
//                waits for GO and up while the reaction is being timed.
//  Revision    : 1.0 - initial release
// ============================================================================
module trial_timer
   import reaction_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [DELAY_W-1:0] i_load_val,
   input  logic               i_down,
   input  logic               i_up,
   output logic [DELAY_W-1:0] o_count
);

   logic [DELAY_W-1:0] r_count;

   // Load has priority; the down-count saturates at zero so a zero delay
   // cannot wrap into a huge one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_down && (r_count != '0)) begin
         r_count <= r_count - DELAY_W'(1);
      end else if (i_up) begin
         r_count <= r_count + DELAY_W'(1);
      end
   end

   assign o_count = r_count;

endmodule : trial_timer
`default_nettype wire

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_ctrl
//  Description : Reaction-time game controller. Start arms a random delay,
//                GO lights the LED, and Stop measures the reaction in ms.
//                Early presses flag Cheat; slow ones flag Timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
   parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              MsTick,
   input  logic              Start,
   input  logic              Stop,
   input  logic [TIME_W-1:0] RandomValue,
   output logic              Led,
   output logic [TIME_W-1:0] ReactionTime,
   output logic              Valid,
   output logic              Cheat,
   output logic              Timeout,
   output logic              Busy
);

   state_t              r_state, w_state_nxt;
   logic                r_led, w_led_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_cheat, w_cheat_nxt;
   logic                r_tout, w_tout_nxt;
   logic                r_busy, w_busy_nxt;
   logic [TIME_W-1:0]   r_rt, w_rt_nxt;

   logic                w_load, w_down, w_up;
   logic [DELAY_W-1:0]  w_count;
   logic [DELAY_W-1:0]  w_cnt_inc;
   logic [DELAY_W-1:0]  w_load_val;
   logic                w_expire;
   logic                w_unused_rand;

   // Only the low 12 random bits shape the delay.
   assign w_unused_rand = RandomValue[TIME_W-1];
   assign w_load_val    = DELAY_W'(MIN_DELAY_MS) + {2'b00, RandomValue[11:0]};
   // The tick seen while the count is 1 (or already 0) ends the wait.
   assign w_expire      = (w_count <= DELAY_W'(1));
   // In GO the timer counts up from zero, so count+1 is the new reaction time.
   assign w_cnt_inc     = w_count + DELAY_W'(1);

   trial_timer u_timer (
      .clk        (Clk),
      .rst        (Rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_down     (w_down),
      .i_up       (w_up),
      .o_count    (w_count)
   );

   // Next-state and next-output decode; Stop always beats a same-cycle tick.
   always_comb begin
      w_state_nxt = r_state;
      w_led_nxt   = r_led;
      w_valid_nxt = r_valid;
      w_cheat_nxt = r_cheat;
      w_tout_nxt  = r_tout;
      w_rt_nxt    = r_rt;
      w_load      = 1'b0;
      w_down      = 1'b0;
      w_up        = 1'b0;

      case (r_state)
         WAIT: begin
            if (Stop) begin
               w_state_nxt = CHEAT;
               w_cheat_nxt = 1'b1;
               w_led_nxt   = 1'b0;
            end else if (MsTick) begin
               w_down = 1'b1;
               if (w_expire) begin
                  w_state_nxt = GO;
                  w_led_nxt   = 1'b1;
               end
            end
         end
         GO: begin
            if (Stop) begin
               w_state_nxt = DONE;
               w_valid_nxt = 1'b1;
               w_led_nxt   = 1'b0;
            end else if (MsTick) begin
               w_up     = 1'b1;
               w_rt_nxt = w_cnt_inc[TIME_W-1:0];
               if (w_cnt_inc == DELAY_W'(TIMEOUT_MS)) begin
                  w_state_nxt = TOUT;
                  w_tout_nxt  = 1'b1;
                  w_led_nxt   = 1'b0;
               end
            end
         end
         default: begin
            // IDLE, DONE, CHEAT, TOUT: hold results until a new trial.
            if (Start) begin
               w_state_nxt = WAIT;
               w_load      = 1'b1;
               w_led_nxt   = 1'b0;
               w_valid_nxt = 1'b0;
               w_cheat_nxt = 1'b0;
               w_tout_nxt  = 1'b0;
               w_rt_nxt    = '0;
            end
         end
      endcase

      w_busy_nxt = (w_state_nxt == WAIT) || (w_state_nxt == GO);
   end

   // State and output registers; reset overrides every input.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
         r_led   <= 1'b0;
         r_valid <= 1'b0;
         r_cheat <= 1'b0;
         r_tout  <= 1'b0;
         r_busy  <= 1'b0;
         r_rt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_led   <= w_led_nxt;
         r_valid <= w_valid_nxt;
         r_cheat <= w_cheat_nxt;
         r_tout  <= w_tout_nxt;
         r_busy  <= w_busy_nxt;
         r_rt    <= w_rt_nxt;
      end
   end

   assign Led          = r_led;
   assign ReactionTime = r_rt;
   assign Valid        = r_valid;
   assign Cheat        = r_cheat;
   assign Timeout      = r_tout;
   assign Busy         = r_busy;

endmodule : reaction_ctrl
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_ctrl
//  Description : Directed self-checking bench for reaction_ctrl with
//                MIN_DELAY_MS=4 and TIMEOUT_MS=50.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        MsTick = 1'b0;
   logic        Start = 1'b0;
   logic        Stop = 1'b0;
   logic [12:0] RandomValue = '0;
   logic        Led;
   logic [12:0] ReactionTime;
   logic        Valid, Cheat, Timeout, Busy;

   int errors = 0;
   int checks = 0;

   reaction_ctrl #(.MIN_DELAY_MS(4), .TIMEOUT_MS(50)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .MsTick       (MsTick),
      .Start        (Start),
      .Stop         (Stop),
      .RandomValue  (RandomValue),
      .Led          (Led),
      .ReactionTime (ReactionTime),
      .Valid        (Valid),
      .Cheat        (Cheat),
      .Timeout      (Timeout),
      .Busy         (Busy)
   );

   always #5 Clk = ~Clk;

   // Advance one clock; inputs change and outputs are read 1 after the edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start(input logic [12:0] rv);
      Start = 1'b1; RandomValue = rv;
      step();
      Start = 1'b0;
   endtask

   task automatic pulse_stop();
      Stop = 1'b1;
      step();
      Stop = 1'b0;
   endtask

   // Each tick is a one-cycle pulse followed by an idle cycle.
   task automatic ms_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         MsTick = 1'b1; step(); MsTick = 1'b0; step();
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; step(); step(); Rst = 1'b0;
      checks++; if (Led !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", Led); end
      checks++; if (ReactionTime !== 13'd0) begin errors++; $display("FAIL reset_rt got=%0d exp=0", ReactionTime); end
      checks++; if ({Valid, Cheat, Timeout, Busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {Valid, Cheat, Timeout, Busy}); end
   endtask

   // D = 4 + 3 = 7; reaction of 25 ms then Stop.
   task automatic test_normal();
      pulse_start(13'h0003);
      checks++; if ({Busy, Led} !== 2'b10) begin errors++; $display("FAIL norm_wait got=%b exp=10", {Busy, Led}); end
      ms_ticks(6);
      checks++; if (Led !== 1'b0) begin errors++; $display("FAIL norm_led_early got=%b exp=0", Led); end
      MsTick = 1'b1; step(); MsTick = 1'b0;
      checks++; if (Led !== 1'b1) begin errors++; $display("FAIL norm_led_tick7 got=%b exp=1", Led); end
      step();
      ms_ticks(25);
      checks++; if (ReactionTime !== 13'd25) begin errors++; $display("FAIL norm_rt_go got=%0d exp=25", ReactionTime); end
      pulse_stop();
      checks++; if ({Valid, Cheat, Timeout, Led, Busy} !== 5'b10000) begin errors++; $display("FAIL norm_done_flags got=%b exp=10000", {Valid, Cheat, Timeout, Led, Busy}); end
      ms_ticks(2);
      checks++; if (ReactionTime !== 13'd25) begin errors++; $display("FAIL norm_rt_hold got=%0d exp=25", ReactionTime); end
   endtask

   // Early Stop during the wait; the restart also clears the previous Valid.
   task automatic test_cheat();
      logic led_seen;
      led_seen = 1'b0;
      pulse_start(13'h0003);
      checks++; if ({Valid, ReactionTime} !== {1'b0, 13'd0}) begin errors++; $display("FAIL cheat_start_clear got=%b/%0d exp=0/0", Valid, ReactionTime); end
      for (int i = 0; i < 3; i++) begin
         MsTick = 1'b1; step(); MsTick = 1'b0; led_seen |= Led; step(); led_seen |= Led;
      end
      pulse_stop();
      led_seen |= Led;
      checks++; if ({Cheat, Valid, Timeout, Busy} !== 4'b1000) begin errors++; $display("FAIL cheat_flags got=%b exp=1000", {Cheat, Valid, Timeout, Busy}); end
      checks++; if (led_seen !== 1'b0) begin errors++; $display("FAIL cheat_led_seen got=%b exp=0", led_seen); end
      checks++; if (ReactionTime !== 13'd0) begin errors++; $display("FAIL cheat_rt got=%0d exp=0", ReactionTime); end
      pulse_stop();
      ms_ticks(8);
      checks++; if ({Cheat, Valid, Led, Busy} !== 4'b1000) begin errors++; $display("FAIL cheat_extra_stop got=%b exp=1000", {Cheat, Valid, Led, Busy}); end
   endtask

   // D = 4; no Stop, reaction counter hits 50.
   task automatic test_timeout();
      pulse_start(13'h0000);
      ms_ticks(4);
      checks++; if (Led !== 1'b1) begin errors++; $display("FAIL tout_go_led got=%b exp=1", Led); end
      ms_ticks(49);
      checks++; if ({ReactionTime, Timeout, Led} !== {13'd49, 1'b0, 1'b1}) begin errors++; $display("FAIL tout_49 got=%0d/%b/%b exp=49/0/1", ReactionTime, Timeout, Led); end
      ms_ticks(1);
      checks++; if ({ReactionTime, Timeout, Led, Busy, Valid} !== {13'd50, 1'b1, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL tout_50 got=%0d/%b/%b/%b/%b exp=50/1/0/0/0", ReactionTime, Timeout, Led, Busy, Valid); end
      ms_ticks(3);
      checks++; if (ReactionTime !== 13'd50) begin errors++; $display("FAIL tout_rt_hold got=%0d exp=50", ReactionTime); end
   endtask

   // Start ignored in WAIT; Stop+tick in GO counts no tick.
   task automatic test_simultaneous();
      pulse_start(13'h0000);
      ms_ticks(2);
      pulse_start(13'h0FFF);
      ms_ticks(2);
      checks++; if (Led !== 1'b1) begin errors++; $display("FAIL sim_start_in_wait led=%b exp=1", Led); end
      ms_ticks(10);
      Stop = 1'b1; MsTick = 1'b1; step(); Stop = 1'b0; MsTick = 1'b0;
      checks++; if ({ReactionTime, Valid, Led} !== {13'd10, 1'b1, 1'b0}) begin errors++; $display("FAIL sim_stop_tick got=%0d/%b/%b exp=10/1/0", ReactionTime, Valid, Led); end
      // Stop coinciding with the would-be timeout tick wins.
      pulse_start(13'h0000);
      ms_ticks(4);
      ms_ticks(49);
      Stop = 1'b1; MsTick = 1'b1; step(); Stop = 1'b0; MsTick = 1'b0;
      checks++; if ({ReactionTime, Valid, Timeout} !== {13'd49, 1'b1, 1'b0}) begin errors++; $display("FAIL sim_stop_vs_tout got=%0d/%b/%b exp=49/1/0", ReactionTime, Valid, Timeout); end
   endtask

   // Reset mid-GO overrides same-cycle inputs; next trial uses D = 4 + 1 = 5.
   task automatic test_reset_mid();
      pulse_start(13'h0000);
      ms_ticks(4);
      ms_ticks(12);
      checks++; if (ReactionTime !== 13'd12) begin errors++; $display("FAIL rmid_rt12 got=%0d exp=12", ReactionTime); end
      Rst = 1'b1; Start = 1'b1; MsTick = 1'b1; Stop = 1'b1;
      step();
      Rst = 1'b0; Start = 1'b0; MsTick = 1'b0; Stop = 1'b0;
      checks++; if ({Led, ReactionTime, Valid, Cheat, Timeout, Busy} !== 18'd0) begin errors++; $display("FAIL rmid_outputs got=%b/%0d/%b%b%b%b exp=0/0/0000", Led, ReactionTime, Valid, Cheat, Timeout, Busy); end
      step();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_idle busy=%b exp=0", Busy); end
      pulse_start(13'h1001);
      ms_ticks(4);
      checks++; if (Led !== 1'b0) begin errors++; $display("FAIL rmid_led_tick4 got=%b exp=0", Led); end
      MsTick = 1'b1; step(); MsTick = 1'b0;
      checks++; if (Led !== 1'b1) begin errors++; $display("FAIL rmid_led_tick5 got=%b exp=1", Led); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_cheat();
      test_timeout();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_reaction_ctrl
`default_nettype wire

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 SHALL have parameter MIN_DELAY_MS, default 1000: fixed part of the pre-GO delay, in ms.
REQ-002 SHALL have parameter TIMEOUT_MS, default 2000: reaction time at which the trial aborts, in ms.
REQ-003 SHALL have port Clk  in  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port MsTick  in  1: one-Clk enable pulse per millisecond.
REQ-006 SHALL have port Start  in  1: debounced single-cycle pulse that begins a trial.
REQ-007 SHALL have port Stop  in  1: debounced single-cycle pulse for the player press.
REQ-008 SHALL have port RandomValue  in  13: free-running LFSR value.
REQ-009 SHALL have port Led  out  1: GO light.
REQ-010 SHALL have port ReactionTime  out  13: measured reaction time in ms.
REQ-011 SHALL have port Valid  out  1: a good result is held.
REQ-012 SHALL have port Cheat  out  1: Stop arrived before GO.
REQ-013 SHALL have port Timeout  out  1: no Stop arrived within TIMEOUT_MS.
REQ-014 SHALL have port Busy  out  1: the block is in WAIT or GO.

Function
REQ-015 SHALL implement states IDLE, WAIT, GO, DONE, CHEAT, TOUT; all outputs registered.
REQ-016 In IDLE/DONE/CHEAT/TOUT, Start SHALL: go to WAIT next cycle; load delay D = MIN_DELAY_MS + RandomValue[11:0] (14-bit, unsigned, sampled that cycle); clear ReactionTime, Valid, Cheat, Timeout.
REQ-017 In WAIT, each MsTick SHALL decrement the delay counter; the MsTick that takes it to 0 SHALL move to GO. Led rises the following cycle, exactly D ticks after Start.
REQ-018 In WAIT, Stop SHALL move to CHEAT and set Cheat=1, Led=0. Stop has priority over a same-cycle expiring MsTick.
REQ-019 In GO, Led SHALL be 1 and each MsTick SHALL increment ReactionTime by 1.
REQ-020 In GO, Stop SHALL move to DONE, set Valid=1 and Led=0, and freeze ReactionTime. A MsTick in the same cycle as Stop SHALL NOT be counted.
REQ-021 In GO, the MsTick that makes ReactionTime equal TIMEOUT_MS SHALL move to TOUT, set Timeout=1 and Led=0, and hold ReactionTime=TIMEOUT_MS. A simultaneous Stop wins: DONE with ReactionTime unchanged.
REQ-022 Start SHALL be ignored in WAIT and GO; Stop SHALL be ignored in IDLE, DONE, CHEAT and TOUT.
REQ-023 DONE/CHEAT/TOUT SHALL hold all outputs until Start or Rst.
REQ-024 Busy SHALL be 1 exactly in WAIT and GO.
REQ-025 Valid, Cheat and Timeout SHALL be mutually exclusive.
REQ-026 ReactionTime SHALL never exceed TIMEOUT_MS, which SHALL be at most 8191.

Reset
REQ-027 Rst SHALL, on the next Clk edge, force IDLE, Led=0, ReactionTime=0, Valid=0, Cheat=0, Timeout=0, Busy=0, delay counter=0.
REQ-028 Rst SHALL override Start, Stop and MsTick in the same cycle, including mid-WAIT or mid-GO.

Structure
REQ-029 Package reaction_pkg SHALL hold the state enum, DELAY_W=14, TIME_W=13, and the MIN_DELAY_MS and TIMEOUT_MS defaults.
REQ-030 One sub-module, trial_timer, SHALL implement the loadable 14-bit ms counter: down-count in WAIT, up-count in GO, gated by MsTick.
REQ-031 The LFSR SHALL remain external; reaction_ctrl SHALL only sample RandomValue.

Verification (MIN_DELAY_MS=4, TIMEOUT_MS=50)
REQ-032 RandomValue=13'h0003, Start, 7 MsTicks -> Led=1 the cycle after tick 7; 25 ticks then Stop -> Valid=1, ReactionTime=25, Led=0.
REQ-033 Start, 3 MsTicks, Stop -> Cheat=1, Led never 1, ReactionTime=0; extra Stop ignored.
REQ-034 Reach GO, 50 ticks, no Stop -> Timeout=1, ReactionTime=50, Led=0.
REQ-035 In GO after 10 ticks, Stop and MsTick in the same cycle -> ReactionTime=10, Valid=1; Start in WAIT -> no effect on the delay.
REQ-036 Rst asserted in GO at ReactionTime=12 -> next cycle all outputs 0, IDLE; then Start with RandomValue=13'h1001 -> D=5, Led rises after tick 5.
